// File: rtl/gal22v10_vector_sequencer.sv
// Sweeps every IN_W-bit vector into a GAL-style DUT, samples IOQ after SETTLE cycles, folds it into a MISR.
// One record per vector on CAP_*; SETTLE+1 cycles/vector unstalled; CAP_READY low freezes I, record and SIG.
module gal22v10_vector_sequencer #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned SIG_W  = 16,
  parameter logic [31:0] POLY   = 32'h1021
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             START,
  input  logic             ABORT,
  output logic [IN_W-1:0]  I,
  input  logic [OUT_W-1:0] IOQ,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic             CAP_VALID,
  input  logic             CAP_READY,
  output logic [IN_W-1:0]  CAP_I,
  output logic [OUT_W-1:0] CAP_O
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;

  localparam logic [SIG_W-1:0] POLY_V    = POLY[SIG_W-1:0];
  localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [IN_W-1:0]  i_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_nxt;
  logic             busy_q;
  logic             done_q;
  logic             cap_vld_q;
  logic [IN_W-1:0]  cap_i_q;
  logic [OUT_W-1:0] cap_o_q;

  always_comb begin
    sig_nxt = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY_V : '0) ^ SIG_W'(IOQ);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      i_q       <= '0;
      sig_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_i_q   <= '0;
      cap_o_q   <= '0;
    end else if (ABORT) begin
      // SIG is deliberately left alone so the partial signature stays observable.
      state     <= S_IDLE;
      cnt       <= '0;
      i_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cap_vld_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state  <= S_SETTLE;
            cnt    <= SETTLE_M1;
            i_q    <= '0;
            sig_q  <= '1;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd0) begin
            state     <= S_EMIT;
            cap_o_q   <= IOQ;
            cap_i_q   <= i_q;
            sig_q     <= sig_nxt;
            cap_vld_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_EMIT: begin
          if (CAP_READY) begin
            cap_vld_q <= 1'b0;
            if (i_q == {IN_W{1'b1}}) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= S_SETTLE;
              i_q   <= i_q + IN_W'(1);
              cnt   <= SETTLE_M1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign I         = i_q;
  assign SIG       = sig_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CAP_VALID = cap_vld_q;
  assign CAP_I     = cap_i_q;
  assign CAP_O     = cap_o_q;

endmodule

// File: tb/tb_gal22v10_vector_sequencer.sv
// Directed bench: default sweep with loopback DUT, plus a 1-bit instance for hand-computed MISR values.
module tb_gal22v10_vector_sequencer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cap_ready = 1'b1;
  logic [11:0] i_o, cap_i;
  logic [9:0]  ioq, cap_o;
  logic        busy, done, cap_valid;
  logic [15:0] sig;

  logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
  logic [0:0]  i2, ioq2, cap_i2, cap_o2;
  logic        busy2, done2, cv2;
  logic [3:0]  sig2;

  int n_assert = 0;
  int n_fail   = 0;

  assign ioq  = i_o[9:0];
  assign ioq2 = i2;

  always #5 clk = ~clk;

  gal22v10_vector_sequencer u_dut (
    .CLK(clk), .nRESET(nreset), .START(start), .ABORT(abort), .I(i_o), .IOQ(ioq),
    .BUSY(busy), .DONE(done), .SIG(sig), .CAP_VALID(cap_valid), .CAP_READY(cap_ready),
    .CAP_I(cap_i), .CAP_O(cap_o)
  );

  gal22v10_vector_sequencer #(.IN_W(1), .OUT_W(1), .SIG_W(4), .POLY(32'h3)) u_small (
    .CLK(clk), .nRESET(nreset), .START(start2), .ABORT(abort2), .I(i2), .IOQ(ioq2),
    .BUSY(busy2), .DONE(done2), .SIG(sig2), .CAP_VALID(cv2), .CAP_READY(ready2),
    .CAP_I(cap_i2), .CAP_O(cap_o2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next capture record; n counts edges taken.
  task automatic wait_rec(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cap_valid && n < 50);
  endtask

  function automatic logic [15:0] misr16(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0} ^ {6'b0, d};
    if (s[15]) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_i"}, 32'(i_o), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sig"}, 32'(sig), 0);
    chk({tag, "_cv"}, 32'(cap_valid), 0);
    chk({tag, "_capi"}, 32'(cap_i), 0);
    chk({tag, "_capo"}, 32'(cap_o), 0);
  endtask

  initial begin
    int n;
    int stall;
    logic [15:0] m;

    // Reset values
    #12;
    chk_reset_vals("rst");
    nreset = 1'b1;
    tick();
    tick();

    // Small instance: seed F, vector 0 -> D, vector 1 -> 8
    start2 = 1'b1;
    n = 0;
    do begin tick(); start2 = 1'b0; n++; end while (!cv2 && n < 20);
    chk("small_v0_lat", 32'(n), 5);
    chk("small_v0_sig", 32'(sig2), 32'hD);
    chk("small_v0_capi", 32'(cap_i2), 0);
    n = 0;
    do begin tick(); n++; end while (!cv2 && n < 20);
    chk("small_v1_capi", 32'(cap_i2), 1);
    chk("small_v1_capo", 32'(cap_o2), 1);
    chk("small_v1_sig", 32'(sig2), 32'h8);
    tick();
    chk("small_done", 32'(done2), 1);
    chk("small_busy", 32'(busy2), 0);
    chk("small_final_sig", 32'(sig2), 32'h8);

    // START and ABORT together from IDLE: ABORT wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_done", 32'(done), 0);
    tick();
    chk("sa_busy2", 32'(busy), 0);

    // Sweep start; first record SETTLE+1 edges counting the START edge
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_busy", 32'(busy), 1);
    chk("st_sig_seed", 32'(sig), 32'hFFFF);
    chk("st_cv_low", 32'(cap_valid), 0);
    n = 1;
    while (!cap_valid && n < 50) begin tick(); n++; end
    chk("first_lat", 32'(n), 5);
    m = misr16(16'hFFFF, 10'd0);
    chk("v0_capi", 32'(cap_i), 0);
    chk("v0_sig", 32'(sig), 32'(m));

    for (int v = 1; v < 100; v++) begin
      if (v == 2) begin
        // START during BUSY is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_i", 32'(i_o), 2);
        chk("busy_start_busy", 32'(busy), 1);
        wait_rec(n);
        chk("v2_lat", 32'(n), 4);
      end else begin
        wait_rec(n);
        if (v == 4) chk("v4_total_delay", 32'(stall + n), 12);
        else        chk("rec_lat", 32'(n), 5);
      end
      m = misr16(m, v[9:0]);
      chk("rec_capi", 32'(cap_i), 32'(v));
      chk("rec_sig", 32'(sig), 32'(m));
      if (v == 3) begin
        cap_ready = 1'b0;
        stall = 0;
        repeat (7) begin
          tick();
          stall++;
          chk("stall_cv", 32'(cap_valid), 1);
          chk("stall_capi", 32'(cap_i), 3);
          chk("stall_capo", 32'(cap_o), 3);
          chk("stall_i", 32'(i_o), 3);
        end
        chk("stall_sig", 32'(sig), 32'(m));
        cap_ready = 1'b1;
      end
    end

    // ABORT during SETTLE of vector 100
    tick();
    chk("pre_abort_i", 32'(i_o), 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_i", 32'(i_o), 0);
    chk("abort_cv", 32'(cap_valid), 0);
    chk("abort_sig", 32'(sig), 32'(m));

    // Restart after abort
    start = 1'b1;
    wait_rec(n);
    start = 1'b0;
    chk("restart_lat", 32'(n), 5);
    chk("restart_capi", 32'(cap_i), 0);
    chk("restart_sig", 32'(sig), 32'(misr16(16'hFFFF, 10'd0)));

    // Asynchronous reset mid-EMIT
    #2;
    nreset = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    chk_reset_vals("arst_hold");
    #2;
    nreset = 1'b1;
    tick();

    // Full sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    m = 16'hFFFF;
    n = 1;
    while (!cap_valid && n < 50) begin tick(); n++; end
    chk("full_first_lat", 32'(n), 5);
    for (int v = 0; v < 4096; v++) begin
      if (v > 0) begin
        wait_rec(n);
        chk("full_lat", 32'(n), 5);
      end
      m = misr16(m, v[9:0]);
      chk("full_capi", 32'(cap_i), 32'(v));
      chk("full_sig", 32'(sig), 32'(m));
    end
    chk("last_busy", 32'(busy), 1);
    chk("last_done", 32'(done), 0);
    tick();
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_cv", 32'(cap_valid), 0);
    chk("end_i", 32'(i_o), 32'hFFF);
    chk("end_sig", 32'(sig), 32'(m));
    tick();
    chk("done_hold_sig", 32'(sig), 32'(m));

    // START from DONE re-seeds and restarts
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redo_busy", 32'(busy), 1);
    chk("redo_done", 32'(done), 0);
    chk("redo_sig", 32'(sig), 32'hFFFF);
    chk("redo_i", 32'(i_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gal22v10_vector_sequencer.md
Name: gal22v10_vector_sequencer

Overview:
Drives an exhaustive input sweep into a GAL22V10-style device under test and captures its outputs. For each input vector the block waits a programmable settle time, then samples IOQ and folds the sample into a MISR signature. It also streams each (vector, sample) pair over a valid/ready capture port. It sits between the DUT's I/IOQ pins and a logger or comparator, and replaces open-loop timed stimulus with clocked, back-pressurable sequencing.

Parameters:
IN_W, 12, width of DUT input vector I; sweep covers 0 .. 2^IN_W-1
OUT_W, 10, width of DUT output bus IOQ
SETTLE, 4, cycles between driving I and sampling IOQ; legal range 1..255
SIG_W, 16, MISR signature width; must be >= OUT_W
POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)

Ports:
CLK  input  1  system clock, rising edge
nRESET  input  1  asynchronous active-low reset
START  input  1  one-cycle pulse; begins a sweep when in IDLE or DONE
ABORT  input  1  terminates any sweep; returns to IDLE
I  output  IN_W  vector driven to the DUT
IOQ  input  OUT_W  DUT outputs; treated as stable after SETTLE cycles
BUSY  output  1  high while a sweep is in progress
DONE  output  1  high after a completed sweep until next START/ABORT
SIG  output  SIG_W  running MISR signature
CAP_VALID  output  1  capture record available
CAP_READY  input  1  consumer accepts record
CAP_I  output  IN_W  vector of current record
CAP_O  output  OUT_W  sampled IOQ of current record

Behaviour:
- Reset (nRESET low, asynchronous): state IDLE; I=0, BUSY=0, DONE=0, SIG=0, CAP_VALID=0, CAP_I=0, CAP_O=0, settle counter=0.
- States: IDLE, SETTLE, EMIT, DONE. BUSY=1 exactly in SETTLE and EMIT. DONE=1 exactly in DONE state.
- IDLE/DONE + START: I<=0, SIG<=all ones (seed), counter<=SETTLE-1, go to SETTLE.
- START while BUSY is ignored.
- SETTLE: counter decrements each cycle. When counter==0:
  - CAP_O<=IOQ, CAP_I<=I, SIG<=MISR(SIG, IOQ), CAP_VALID<=1.
  - Go to EMIT.
  - SETTLE therefore lasts exactly SETTLE cycles.
- MISR: next = {SIG[SIG_W-2:0],0} ^ (SIG[SIG_W-1] ? POLY : 0) ^ zero-extend(IOQ). Updated once per vector, never on stall cycles.
- EMIT: CAP_VALID, CAP_I and CAP_O are held stable until CAP_READY is high. On the handshake cycle (VALID&READY):
  - If I == 2^IN_W-1: CAP_VALID<=0, go to DONE. I holds its last value.
  - Else: I<=I+1 (no wrap), counter<=SETTLE-1, CAP_VALID<=0, go to SETTLE.
- Timing:
  - With CAP_READY tied high, each vector takes SETTLE+1 cycles.
  - CAP_VALID first rises SETTLE+1 edges after the edge that samples START.
  - A full sweep takes 2^IN_W*(SETTLE+1) cycles.
- I changes only on the edge that enters SETTLE. It is never changed while CAP_VALID=1.
- ABORT, any state: go to IDLE; I<=0, CAP_VALID<=0, BUSY=0, DONE=0. SIG retains its last value.
  - ABORT and START in the same cycle: ABORT wins; the state is IDLE on the next cycle.
- DONE state: SIG holds the final signature. START from DONE re-seeds SIG and restarts from vector 0.
- Reset asserted mid-sweep: immediate return to the reset values above. No record is emitted.

Test Plan:
- Defaults, CAP_READY=1, IOQ=I[9:0] loopback, START at cycle 10 -> CAP_VALID first high at cycle 15; records appear every 5 cycles with CAP_I=0,1,2..; DONE rises after 4096 records (20480 cycles); BUSY falls the same cycle DONE rises.
- IN_W=1, OUT_W=1, SIG_W=4, POLY=4'h3, IOQ=I[0] -> SIG=4'hD after vector 0, 4'h8 after vector 1; DONE=1 with SIG=4'h8.
- Back-pressure: CAP_READY low for 7 cycles on vector 3 -> CAP_I=3 and CAP_O held; I stays 3; SIG updated once only; vector 4 appears 7 cycles later than the unstalled case.
- ABORT asserted in SETTLE of vector 100 -> next cycle IDLE, BUSY=0, I=0, CAP_VALID=0; SIG equals the value after vector 99. A following START restarts at CAP_I=0 with seed FFFF.
- START+ABORT in the same cycle from IDLE -> stays IDLE, BUSY=0. START pulsed during BUSY -> sweep continues unaffected.
- nRESET pulsed low asynchronously mid-EMIT -> all outputs reach their reset values before the next CLK edge; no handshake is completed.
